// File: rtl/dmem_pkg.sv
// Shared definitions for the block data memory and its cache-side port.
package dmem_pkg;

  localparam int BLOCK_ADDR_W = 6;
  localparam int BLOCK_W      = 32;
  localparam int MEM_BYTES    = 256;
  localparam int COUNT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/block_data_memory_access_timer.sv
// Loadable 8-bit down-counter with a registered zero flag; never wraps below zero.
module access_timer
  import dmem_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [COUNT_W-1:0] value,
  input  logic               enable,
  output logic               zero
);

  logic [COUNT_W-1:0] count_r;
  logic               zero_r;

  // Load, decrement (saturating at zero) and track the zero flag alongside the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= 8'd0;
      zero_r  <= 1'b1;
    end else if (load) begin
      count_r <= value;
      zero_r  <= (value == 8'd0);
    end else if (enable && (count_r != 8'd0)) begin
      count_r <= count_r - 8'd1;
      zero_r  <= (count_r == 8'd1);
    end else begin
      count_r <= count_r;
      zero_r  <= zero_r;
    end
  end

  assign zero = zero_r;

endmodule

// File: rtl/block_data_memory.sv
// Block-granular 256-byte data memory serving whole 4-byte blocks with fixed latency.
module block_data_memory
  import dmem_pkg::*;
#(
  parameter int ACCESS_CYCLES = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    read,
  input  logic                    write,
  input  logic [BLOCK_ADDR_W-1:0] address,
  input  logic [BLOCK_W-1:0]      writedata,
  output logic [BLOCK_W-1:0]      readdata,
  output logic                    busywait
);

  // The IDLE cycle that accepts a request counts as the first busy cycle,
  // and BUSY ends on the edge where the counter is already zero.
  localparam logic [COUNT_W-1:0] LOAD_VALUE = COUNT_W'(ACCESS_CYCLES - 2);

  state_t                  state_r;
  logic [BLOCK_ADDR_W-1:0] addr_r;
  logic [BLOCK_W-1:0]      wdata_r;
  logic                    op_write_r;
  logic [BLOCK_W-1:0]      readdata_r;
  logic [7:0]              mem_r [MEM_BYTES];

  logic valid_s;
  logic load_s;
  logic enable_s;
  logic busy_s;
  logic timer_zero_s;

  // Exactly one of read/write makes a request; both high is ignored.
  assign valid_s = read ^ write;

  access_timer u_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (load_s),
    .value  (LOAD_VALUE),
    .enable (enable_s),
    .zero   (timer_zero_s)
  );

  // Decode timer controls and the busy indication from the current state.
  always_comb begin
    load_s   = 1'b0;
    enable_s = 1'b0;
    busy_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (valid_s) begin
          load_s = 1'b1;
          busy_s = 1'b1;
        end else begin
          load_s = 1'b0;
          busy_s = 1'b0;
        end
      end
      ST_BUSY: begin
        enable_s = 1'b1;
        busy_s   = 1'b1;
      end
      ST_DONE: begin
        busy_s = 1'b0;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Gate with reset so busywait drops at once even while a request is still held.
  assign busywait = busy_s & reset;
  assign readdata = readdata_r;

  // Access FSM: capture the request, wait out the latency, then commit or fetch the block.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      addr_r     <= 6'd0;
      wdata_r    <= 32'h0;
      op_write_r <= 1'b0;
      readdata_r <= 32'h0;
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (valid_s) begin
            addr_r     <= address;
            wdata_r    <= writedata;
            op_write_r <= write;
            state_r    <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (timer_zero_s) begin
            if (op_write_r) begin
              mem_r[{addr_r, 2'd0}] <= wdata_r[7:0];
              mem_r[{addr_r, 2'd1}] <= wdata_r[15:8];
              mem_r[{addr_r, 2'd2}] <= wdata_r[23:16];
              mem_r[{addr_r, 2'd3}] <= wdata_r[31:24];
            end else begin
              readdata_r <= {mem_r[{addr_r, 2'd3}], mem_r[{addr_r, 2'd2}],
                             mem_r[{addr_r, 2'd1}], mem_r[{addr_r, 2'd0}]};
            end
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_data_memory.sv
// Directed and randomized bench for block_data_memory at three access latencies.
module tb_block_data_memory;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        rd    [3];
  logic        wr    [3];
  logic [5:0]  addr  [3];
  logic [31:0] wd    [3];
  logic [31:0] rdata [3];
  logic        busy  [3];

  int ac [3] = '{5, 2, 256};

  int checks = 0;
  int errors = 0;

  // Reference model: plain byte arrays plus the last value read, per instance.
  logic [7:0]  ref_mem [3][256];
  logic [31:0] ref_rd  [3];

  block_data_memory #(.ACCESS_CYCLES(5)) dut0 (
    .clock(clock), .reset(reset), .read(rd[0]), .write(wr[0]), .address(addr[0]),
    .writedata(wd[0]), .readdata(rdata[0]), .busywait(busy[0]));
  block_data_memory #(.ACCESS_CYCLES(2)) dut1 (
    .clock(clock), .reset(reset), .read(rd[1]), .write(wr[1]), .address(addr[1]),
    .writedata(wd[1]), .readdata(rdata[1]), .busywait(busy[1]));
  block_data_memory #(.ACCESS_CYCLES(256)) dut2 (
    .clock(clock), .reset(reset), .read(rd[2]), .write(wr[2]), .address(addr[2]),
    .writedata(wd[2]), .readdata(rdata[2]), .busywait(busy[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_block(input int d, input int a);
    return {ref_mem[d][4*a+3], ref_mem[d][4*a+2], ref_mem[d][4*a+1], ref_mem[d][4*a]};
  endfunction

  task automatic ref_clear();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 256; i++) ref_mem[d][i] = 8'h00;
      ref_rd[d] = 32'h0;
    end
  endtask

  // One complete access: raise request at a falling edge, count busy cycles, check DONE.
  task automatic do_access(input int d, input bit is_wr, input logic [5:0] a,
                           input logic [31:0] data, input bit scramble);
    int cyc;
    bit done;
    @(negedge clock);
    rd[d] = !is_wr; wr[d] = is_wr; addr[d] = a; wd[d] = data;
    #1;
    check("busy_cycle0", {31'd0, busy[d]}, 32'd1);
    cyc = 1;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clock);
      if (busy[d]) begin
        cyc++;
        if (scramble) begin
          addr[d] = 6'($urandom);
          wd[d]   = $urandom;
        end
      end else begin
        done = 1'b1;
      end
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("busy_len", cyc, ac[d]);
    if (is_wr) begin
      for (int k = 0; k < 4; k++) ref_mem[d][4*a+k] = data[8*k +: 8];
    end else begin
      ref_rd[d] = ref_block(d, a);
    end
    check("readdata", rdata[d], ref_rd[d]);
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 6'd0; wd[d] = 32'h0;
    end
    ref_clear();

    // Reset with a read already pending: busywait must stay low.
    reset = 1'b0;
    rd[0] = 1'b1;
    #1;
    check("reset_busy", {31'd0, busy[0]}, 32'd0);
    check("reset_rdata", rdata[0], 32'h0);
    @(negedge clock);
    @(negedge clock);
    rd[0] = 1'b0;
    reset = 1'b1;

    // Read of a fresh block.
    do_access(0, 1'b0, 6'd5, 32'h0, 1'b0);

    // Write then read back, plus the byte-level placement.
    do_access(0, 1'b1, 6'd42, 32'hDEADBEEF, 1'b0);
    do_access(0, 1'b0, 6'd42, 32'h0, 1'b0);
    check("byte168", {24'd0, dut0.mem_r[168]}, {24'd0, 8'hEF});
    check("byte171", {24'd0, dut0.mem_r[171]}, {24'd0, 8'hDE});
    do_access(0, 1'b0, 6'd41, 32'h0, 1'b0);

    // Write-back then fetch with no gap after DONE.
    do_access(0, 1'b1, 6'd35, 32'h55667788, 1'b0);
    do_access(0, 1'b1, 6'd3, 32'h11223344, 1'b0);
    do_access(0, 1'b0, 6'd35, 32'h0, 1'b0);
    do_access(0, 1'b0, 6'd3, 32'h0, 1'b0);

    // Inputs wiggle every BUSY cycle; only block 7 may change.
    do_access(0, 1'b1, 6'd7, 32'hCAFEF00D, 1'b1);
    for (int b = 0; b < 64; b++) do_access(0, 1'b0, 6'(b), 32'h0, 1'b0);

    // Both read and write high: ignored.
    @(negedge clock);
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 6'd10; wd[0] = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("illegal_busy", {31'd0, busy[0]}, 32'd0);
      @(negedge clock);
    end
    rd[0] = 1'b0; wr[0] = 1'b0;
    do_access(0, 1'b0, 6'd10, 32'h0, 1'b0);

    // Reset in the third BUSY cycle of a write aborts it and clears storage.
    @(negedge clock);
    wr[0] = 1'b1; addr[0] = 6'd9; wd[0] = 32'hA5A5A5A5;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    #1;
    check("pre_reset_busy", {31'd0, busy[0]}, 32'd1);
    reset = 1'b0;
    #1;
    check("midreset_busy", {31'd0, busy[0]}, 32'd0);
    check("midreset_rdata", rdata[0], 32'h0);
    ref_clear();
    wr[0] = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    do_access(0, 1'b0, 6'd9, 32'h0, 1'b0);
    do_access(0, 1'b0, 6'd42, 32'h0, 1'b0);

    // Randomized traffic over a small address window to force reuse.
    for (int i = 0; i < 40; i++) begin
      do_access(0, 1'($urandom), 6'($urandom_range(0, 15)), $urandom, 1'b0);
    end

    // Latency extremes.
    do_access(1, 1'b1, 6'd20, 32'h0BADF00D, 1'b0);
    do_access(1, 1'b0, 6'd20, 32'h0, 1'b0);
    do_access(1, 1'b0, 6'd21, 32'h0, 1'b0);
    do_access(2, 1'b1, 6'd63, 32'h89ABCDEF, 1'b0);
    do_access(2, 1'b0, 6'd63, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
